// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one single-port memory between the instruction-fetch
// and load/store ports; each grant runs a fixed-length access followed by an ack cycle.
module mem_port_arbiter #(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int MEM_LATENCY = 2
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              ireq,
    input  logic [ADDR_W-1:0] iaddr,
    output logic [DATA_W-1:0] irdata,
    output logic              iack,
    input  logic              dreq,
    input  logic              dwe,
    input  logic [ADDR_W-1:0] daddr,
    input  logic [DATA_W-1:0] dwdata,
    output logic [DATA_W-1:0] drdata,
    output logic              dack,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy,
    output logic              owner_d
);

    localparam int LAT   = (MEM_LATENCY < 1) ? 1 : MEM_LATENCY;
    localparam int CNT_W = $clog2(LAT) + 1;

    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

    state_t            state;
    state_t            state_next;
    logic              owner_q;
    logic              last_owner;
    logic              we_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [CNT_W-1:0]  cnt;
    logic              winner;

    // A lone requester wins; on contention the port that did not win last time gets it.
    assign winner  = dreq & (~ireq | ~last_owner);
    assign owner_d = owner_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        mem_en     = 1'b0;
        mem_we     = 1'b0;
        mem_addr   = '0;
        mem_wdata  = '0;
        iack       = 1'b0;
        dack       = 1'b0;
        busy       = 1'b0;
        case (state)
            IDLE: begin
                if (ireq | dreq) begin
                    state_next = ACCESS;
                end
            end
            ACCESS: begin
                busy      = 1'b1;
                mem_en    = 1'b1;
                mem_we    = we_q;
                mem_addr  = addr_q;
                mem_wdata = wdata_q;
                if (cnt == '0) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                busy       = 1'b1;
                iack       = ~owner_q;
                dack       = owner_q;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // The memory is driven only from these latched copies, so port inputs may change mid-access.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            owner_q    <= 1'b0;
            last_owner <= 1'b1;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            cnt        <= '0;
            irdata     <= '0;
            drdata     <= '0;
        end else if (state == IDLE) begin
            if (ireq | dreq) begin
                owner_q    <= winner;
                last_owner <= winner;
                addr_q     <= winner ? daddr : iaddr;
                we_q       <= winner & dwe;
                wdata_q    <= winner ? dwdata : '0;
                cnt        <= CNT_W'(LAT - 1);
            end
        end else if (state == ACCESS) begin
            if (cnt == '0) begin
                if (!we_q) begin
                    if (owner_q) begin
                        drdata <= mem_rdata;
                    end else begin
                        irdata <= mem_rdata;
                    end
                end
            end else begin
                cnt <= cnt - CNT_W'(1);
            end
        end
    end

endmodule
